// File: rtl/othello_pkg.sv
// Shared definitions for the Othello turn/move controller:
// cell codes, board dimensions, disc limit and the controller state encoding.
package othello_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_S0    = 2'b10;
    localparam logic [1:0] CELL_S1    = 2'b11;

    localparam int BOARD_DIM = 8;
    localparam int COORD_W   = $clog2(BOARD_DIM);

    localparam logic [5:0] MAX_DISCS = 6'd60;

    typedef enum logic [2:0] {
        IDLE,
        DETECT,
        WAIT_DET,
        CHECK,
        WRITE,
        WAIT_WR,
        SWAP,
        REJECT
    } state_t;

    // Cell code of the disc owned by the given side.
    function automatic logic [1:0] side_cell(input logic side);
        return side ? CELL_S1 : CELL_S0;
    endfunction

endpackage

// File: rtl/othello_move_ctrl_if.sv
// Bundle between the move controller and its environment (keys, board store,
// display). master = controller side, slave = environment side.
interface othello_move_ctrl_if;
    import othello_pkg::*;

    logic               key_up;
    logic               key_down;
    logic               key_left;
    logic               key_right;
    logic               key_place;
    logic [1:0]         q_in;
    logic [7:0]         dir_in;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic               side;
    logic               detect_en;
    logic               write_en;
    logic               busy;
    logic               illegal;
    logic               turn_done;
    logic [5:0]         move_count;
    logic               cursor_vis;

    modport master (
        input  key_up, key_down, key_left, key_right, key_place, q_in, dir_in,
        output cur_x, cur_y, side, detect_en, write_en, busy, illegal,
               turn_done, move_count, cursor_vis
    );

    modport slave (
        output key_up, key_down, key_left, key_right, key_place, q_in, dir_in,
        input  cur_x, cur_y, side, detect_en, write_en, busy, illegal,
               turn_done, move_count, cursor_vis
    );

endinterface

// File: rtl/othello_move_ctrl_key_edge.sv
// Registered rising-edge detector for a vector of debounced key levels.
// A held level produces exactly one single-cycle pulse, one cycle late.
module key_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_key,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge;

    // Remember last level and register the 0->1 transitions.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_prev <= i_key;
            r_edge <= i_key & ~r_prev;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/othello_move_ctrl.sv
// Turn/move controller upstream of the board store: moves the cursor from key
// edges, runs detect -> write -> turn swap for a placement, flags rejections.
// Optional cursor blink: define OTHELLO_CURSOR_BLINK_EN (adds BLINK_DIV).
module othello_move_ctrl
    import othello_pkg::*;
#(
    parameter int DET_CYCLES = 10,
    parameter int WR_CYCLES  = 10
`ifdef OTHELLO_CURSOR_BLINK_EN
    ,
    parameter int BLINK_DIV  = 12500000
`endif
) (
    input  logic                 clock,
    input  logic                 resetn,
    othello_move_ctrl_if.master  bus
);

    localparam int MAX_CYC = (DET_CYCLES > WR_CYCLES) ? DET_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] DET_LOAD = CNT_W'(DET_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Edge vector bit positions.
    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_DOWN  = 2;
    localparam int K_UP    = 3;
    localparam int K_PLACE = 4;

    logic [4:0]         w_keys;
    logic [4:0]         w_edge;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [COORD_W-1:0] r_cur_x;
    logic [COORD_W-1:0] r_cur_y;
    logic               r_side;
    logic               r_detect_en;
    logic               r_write_en;
    logic               r_busy;
    logic               r_illegal;
    logic               r_turn_done;
    logic [5:0]         r_move_count;

    assign w_keys = {bus.key_place, bus.key_up, bus.key_down, bus.key_left, bus.key_right};

    key_edge #(.WIDTH(5)) u_key_edge (
        .clock  (clock),
        .resetn (resetn),
        .i_key  (w_keys),
        .o_edge (w_edge)
    );

    // Controller FSM; all status/request outputs are registered here.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_cur_x      <= 3'd3;
            r_cur_y      <= 3'd2;
            r_side       <= 1'b0;
            r_detect_en  <= 1'b0;
            r_write_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_illegal    <= 1'b0;
            r_turn_done  <= 1'b0;
            r_move_count <= 6'd0;
        end else begin
            r_detect_en <= 1'b0;
            r_write_en  <= 1'b0;
            r_turn_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge[K_PLACE]) begin
                        r_illegal <= 1'b0;
                        r_busy    <= 1'b1;
                        if (bus.q_in != CELL_EMPTY) begin
                            r_state <= REJECT;
                        end else begin
                            r_state     <= DETECT;
                            r_detect_en <= 1'b1;
                        end
                    end else if (w_edge[K_UP]) begin
                        r_illegal <= 1'b0;
                        r_cur_y   <= r_cur_y - 3'd1;
                    end else if (w_edge[K_DOWN]) begin
                        r_illegal <= 1'b0;
                        r_cur_y   <= r_cur_y + 3'd1;
                    end else if (w_edge[K_LEFT]) begin
                        r_illegal <= 1'b0;
                        r_cur_x   <= r_cur_x - 3'd1;
                    end else if (w_edge[K_RIGHT]) begin
                        r_illegal <= 1'b0;
                        r_cur_x   <= r_cur_x + 3'd1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DETECT: begin
                    r_cnt <= DET_LOAD;
                    if (DET_CYCLES == 0) begin
                        r_state <= CHECK;
                    end else begin
                        r_state <= WAIT_DET;
                    end
                end
                WAIT_DET: begin
                    if (r_cnt <= CNT_ONE) begin
                        r_cnt   <= '0;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                CHECK: begin
                    if (bus.dir_in == 8'h00) begin
                        r_state <= REJECT;
                    end else begin
                        r_state    <= WRITE;
                        r_write_en <= 1'b1;
                    end
                end
                WRITE: begin
                    r_cnt <= WR_LOAD;
                    if (WR_CYCLES == 0) begin
                        r_state     <= SWAP;
                        r_turn_done <= 1'b1;
                    end else begin
                        r_state <= WAIT_WR;
                    end
                end
                WAIT_WR: begin
                    if (r_cnt <= CNT_ONE) begin
                        r_cnt       <= '0;
                        r_state     <= SWAP;
                        r_turn_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                SWAP: begin
                    r_side <= ~r_side;
                    if (r_move_count != MAX_DISCS) begin
                        r_move_count <= r_move_count + 6'd1;
                    end else begin
                        r_move_count <= r_move_count;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                REJECT: begin
                    r_illegal <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef OTHELLO_CURSOR_BLINK_EN
    localparam int BL_W = $clog2(BLINK_DIV + 1) + 1;
    localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_DIV - 1);

    logic [BL_W-1:0] r_blink_cnt;
    logic            r_cursor_vis;

    // Blink the cursor while idle; keep it solid when busy or just moved.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_blink_cnt  <= '0;
            r_cursor_vis <= 1'b1;
        end else if (r_busy || ((r_state == IDLE) && (|w_edge))) begin
            r_blink_cnt  <= '0;
            r_cursor_vis <= 1'b1;
        end else if (r_blink_cnt >= BLINK_LAST) begin
            r_blink_cnt  <= '0;
            r_cursor_vis <= ~r_cursor_vis;
        end else begin
            r_blink_cnt <= r_blink_cnt + {{(BL_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.cursor_vis = r_cursor_vis;
`else
    assign bus.cursor_vis = 1'b1;
`endif

    assign bus.cur_x      = r_cur_x;
    assign bus.cur_y      = r_cur_y;
    assign bus.side       = r_side;
    assign bus.detect_en  = r_detect_en;
    assign bus.write_en   = r_write_en;
    assign bus.busy       = r_busy;
    assign bus.illegal    = r_illegal;
    assign bus.turn_done  = r_turn_done;
    assign bus.move_count = r_move_count;

endmodule

// File: tb/tb_othello_move_ctrl.sv
// Scoreboard bench for othello_move_ctrl: stimulus pushes expected outcomes,
// a monitor pops them on cursor moves and on completion of each placement.
`timescale 1ns/1ps
module tb_othello_move_ctrl;

    localparam int DET = 10;
    localparam int WR  = 10;

    localparam logic [4:0] K_R = 5'b00001;
    localparam logic [4:0] K_L = 5'b00010;
    localparam logic [4:0] K_D = 5'b00100;
    localparam logic [4:0] K_U = 5'b01000;
    localparam logic [4:0] K_P = 5'b10000;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    othello_move_ctrl_if bus();

    othello_move_ctrl #(.DET_CYCLES(DET), .WR_CYCLES(WR)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        string      tag;
        bit         is_place;
        logic [2:0] cx;
        logic [2:0] cy;
        logic       side;
        logic [5:0] mc;
        logic       ill;
        int         ndet;
        int         nwr;
        int         nturn;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    logic rst_at_edge = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push_move(input string tag, input int x, input int y);
        exp_t e;
        e.tag = tag; e.is_place = 1'b0; e.cx = 3'(x); e.cy = 3'(y);
        e.side = 1'b0; e.mc = 6'd0; e.ill = 1'b0; e.ndet = 0; e.nwr = 0; e.nturn = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_place(input string tag, input int x, input int y, input int sd,
                              input int mc, input int ill, input int nd, input int nw, input int nt);
        exp_t e;
        e.tag = tag; e.is_place = 1'b1; e.cx = 3'(x); e.cy = 3'(y);
        e.side = 1'(sd); e.mc = 6'(mc); e.ill = 1'(ill); e.ndet = nd; e.nwr = nw; e.nturn = nt;
        exp_q.push_back(e);
    endtask

    // Capture whether the DUT saw reset at each active edge.
    always @(posedge clock) rst_at_edge <= resetn;

    // Monitor / scoreboard.
    logic       m_prev_busy = 1'b0;
    logic [2:0] m_px = 3'd3;
    logic [2:0] m_py = 3'd2;
    int m_ndet = 0, m_nwr = 0, m_nturn = 0, m_cyc = 0, m_det_cyc = 0, m_gap = 0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            m_cyc++;
            if (mon_en) begin
                if (bus.detect_en && bus.write_en) begin
                    n_err++;
                    $display("FAIL req_overlap: detect_en and write_en both 1 at cycle %0d", m_cyc);
                end
                if ((bus.detect_en || bus.write_en || bus.turn_done) && !bus.busy) begin
                    n_err++;
                    $display("FAIL stray_pulse: det=%0d wr=%0d td=%0d while busy=0", bus.detect_en, bus.write_en, bus.turn_done);
                end
                if (bus.busy) begin
                    if (bus.detect_en) begin m_ndet++; m_det_cyc = m_cyc; end
                    if (bus.write_en)  begin m_nwr++;  m_gap = m_cyc - m_det_cyc; end
                    if (bus.turn_done) m_nturn++;
                end
                if (m_prev_busy && !bus.busy) begin
                    if (exp_q.size() == 0 || !exp_q[0].is_place) begin
                        n_err++;
                        $display("FAIL unexpected_place_done: queue size %0d", exp_q.size());
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.tag, ".cur_x"}, bus.cur_x, e.cx);
                        chk({e.tag, ".cur_y"}, bus.cur_y, e.cy);
                        chk({e.tag, ".side"}, bus.side, e.side);
                        chk({e.tag, ".move_count"}, bus.move_count, e.mc);
                        chk({e.tag, ".illegal"}, bus.illegal, e.ill);
                        chk({e.tag, ".detect_pulses"}, m_ndet, e.ndet);
                        chk({e.tag, ".write_pulses"}, m_nwr, e.nwr);
                        chk({e.tag, ".turn_done_pulses"}, m_nturn, e.nturn);
                        if (e.nwr == 1) chk({e.tag, ".det_to_wr_cycles"}, m_gap, DET + 2);
                    end
                    m_ndet = 0; m_nwr = 0; m_nturn = 0;
                end else if ((bus.cur_x != m_px || bus.cur_y != m_py) && rst_at_edge) begin
                    if (bus.busy || m_prev_busy) begin
                        n_err++;
                        $display("FAIL cursor_moved_busy: got (%0d,%0d) was (%0d,%0d)", bus.cur_x, bus.cur_y, m_px, m_py);
                    end else if (exp_q.size() == 0 || exp_q[0].is_place) begin
                        n_err++;
                        $display("FAIL unexpected_move: got (%0d,%0d) was (%0d,%0d)", bus.cur_x, bus.cur_y, m_px, m_py);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.tag, ".cur_x"}, bus.cur_x, e.cx);
                        chk({e.tag, ".cur_y"}, bus.cur_y, e.cy);
                        chk({e.tag, ".illegal"}, bus.illegal, e.ill);
                    end
                end
            end
            m_prev_busy = bus.busy;
            m_px = bus.cur_x;
            m_py = bus.cur_y;
        end
    end

    task automatic press(input logic [4:0] m, input int hold);
        {bus.key_place, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = m;
        repeat (hold) @(negedge clock);
        {bus.key_place, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 5'b00000;
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (!bus.busy && t < 8) begin @(negedge clock); t++; end
        chk({tag, ".busy_rise"}, bus.busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (bus.busy && t < 80) begin @(negedge clock); t++; end
        chk({tag, ".busy_fall"}, bus.busy, 0);
        @(negedge clock);
    endtask

    task automatic do_place(input string tag, input logic [4:0] m);
        press(m, 1);
        wait_start(tag);
        wait_done(tag);
    endtask

    // Cursor walk: key mask, hold cycles, expected (x,y) after the step.
    localparam int NMV = 24;
    logic [4:0] mv_key [NMV] = '{K_R, K_R, K_D, K_U, K_U, K_U, K_L, K_L, K_L, K_L, K_L,
                                 K_L, K_U, K_U|K_L, K_D, K_R, K_R|K_D, K_R, K_R, K_R,
                                 K_D, K_D, K_L|K_R, K_R};
    int mv_hold [NMV] = '{1, 3, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int mv_x [NMV] = '{4, 5, 5, 5, 5, 5, 4, 3, 2, 1, 0, 7, 7, 7, 7, 0, 0, 1, 2, 3, 3, 3, 2, 3};
    int mv_y [NMV] = '{2, 2, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 7, 6, 7, 7, 0, 0, 0, 0, 1, 2, 2, 2};

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k;
        {bus.key_place, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 5'b00000;
        bus.q_in   = 2'b00;
        bus.dir_in = 8'h00;
        resetn     = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst.cur_x", bus.cur_x, 3);
        chk("rst.cur_y", bus.cur_y, 2);
        chk("rst.side", bus.side, 0);
        chk("rst.detect_en", bus.detect_en, 0);
        chk("rst.write_en", bus.write_en, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.illegal", bus.illegal, 0);
        chk("rst.turn_done", bus.turn_done, 0);
        chk("rst.move_count", bus.move_count, 0);
        chk("rst.cursor_vis", bus.cursor_vis, 1);
        resetn = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clock);

        // Cursor movement, priority and wrap.
        for (int i = 0; i < NMV; i++) begin
            push_move($sformatf("move%0d", i), mv_x[i], mv_y[i]);
            press(mv_key[i], mv_hold[i]);
            repeat (3) @(negedge clock);
            chk($sformatf("move%0d.busy", i), bus.busy, 0);
        end

        // Legal placement at (3,2); place wins over a simultaneous right edge.
        bus.q_in = 2'b00; bus.dir_in = 8'h10;
        push_place("place_ok", 3, 2, 1, 1, 0, 1, 1, 1);
        do_place("place_ok", K_P | K_R);

        // Occupied cell -> reject without detect; a right edge clears illegal.
        bus.q_in = 2'b10;
        push_place("occupied", 3, 2, 1, 1, 1, 0, 0, 0);
        do_place("occupied", K_P);
        chk("occupied.illegal_hold", bus.illegal, 1);
        bus.q_in = 2'b00;
        push_move("clear_ill", 4, 2);
        press(K_R, 1);
        repeat (3) @(negedge clock);

        // No legal direction -> reject; keys during WAIT_DET are ignored.
        bus.dir_in = 8'h00;
        push_place("no_dir", 4, 2, 1, 1, 1, 1, 0, 0);
        press(K_P, 1);
        wait_start("no_dir");
        repeat (2) @(negedge clock);
        press(K_L, 1);
        press(K_U, 1);
        wait_done("no_dir");

        // Second legal placement, side back to 0.
        bus.dir_in = 8'h01;
        push_place("place_ok2", 4, 2, 0, 2, 0, 1, 1, 1);
        do_place("place_ok2", K_P);

        // Reset during WAIT_WR: abandoned, no turn_done, all back to reset.
        push_place("rst_mid_wr", 3, 2, 0, 0, 0, 1, 1, 0);
        press(K_P, 1);
        wait_start("rst_mid_wr");
        k = 0;
        while (!bus.write_en && k < 40) begin @(negedge clock); k++; end
        chk("rst_mid_wr.write_seen", bus.write_en, 1);
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("rst_mid_wr.busy", bus.busy, 0);
        chk("rst_mid_wr.turn_done", bus.turn_done, 0);
        repeat (30) @(negedge clock);

        // 61 legal placements: count saturates at 60, side keeps alternating.
        bus.q_in = 2'b00; bus.dir_in = 8'h42;
        for (int n = 1; n <= 61; n++) begin
            push_place($sformatf("turn%0d", n), 3, 2, n % 2, (n > 60) ? 60 : n, 0, 1, 1, 1);
            do_place($sformatf("turn%0d", n), K_P);
        end
        chk("sat.move_count", bus.move_count, 60);
        chk("sat.side", bus.side, 1);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
